// File: rtl/dot_seq_pkg.sv
// Shared definitions for the dot sequencer host-stream blocks: opcodes,
// payload lengths, loader state encoding and lane-count helper.
package dot_seq_pkg;

    localparam logic [7:0] OP_WR_MEM = 8'h01;
    localparam logic [7:0] OP_WR_DOT = 8'h02;
    localparam logic [7:0] OP_WR_SEL = 8'h03;

    localparam logic [2:0] LEN_WR_MEM = 3'd4;
    localparam logic [2:0] LEN_WR_DOT = 3'd3;
    localparam logic [2:0] LEN_WR_SEL = 3'd2;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        ISSUE
    } state_t;

    function automatic int mask_lanes(input int len);
        return (len + 15) / 16;
    endfunction

    localparam int MEM_LENGTH_DEFAULT = 48;
    localparam int MASK_LANES = mask_lanes(MEM_LENGTH_DEFAULT);

    // Zero marks an illegal opcode.
    function automatic logic [2:0] payload_len(input logic [7:0] opcode);
        case (opcode)
            OP_WR_MEM: return LEN_WR_MEM;
            OP_WR_DOT: return LEN_WR_DOT;
            OP_WR_SEL: return LEN_WR_SEL;
            default:   return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dot_seq_loader_timeout.sv
// Inter-byte gap counter: counts enabled cycles since the last clear and
// flags expire on the TIMEOUT_CYCLES-th consecutive enabled cycle.
module dot_seq_loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/dot_sequencer_loader.sv
// Framed command-stream loader: decodes host bytes into single-cycle,
// active-low write strobes for the dot sequencer's pattern, dot and select stores.
module dot_sequencer_loader
    import dot_seq_pkg::*;
#(
    parameter int MEM_LENGTH         = 48,
    parameter int MEM_ADDRESS_LENGTH = 6,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    output logic                          rx_ready,
    output logic [2:0]                    mask_select,
    output logic [MEM_ADDRESS_LENGTH-1:0] mem_address,
    output logic [15:0]                   mem_data,
    output logic                          mem_write_n,
    output logic [15:0]                   mem_dot_data,
    output logic                          mem_dot_write_n,
    output logic [MEM_ADDRESS_LENGTH-1:0] mem_sel_col_address,
    output logic [MEM_ADDRESS_LENGTH-1:0] mem_sel_data,
    output logic                          mem_sel_write_n,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          error,
    input  logic                          err_clear,
    output logic [15:0]                   write_count
);

    localparam logic [8:0] LEN_LIMIT  = 9'(MEM_LENGTH);
    localparam logic [7:0] LANE_LIMIT = 8'(mask_lanes(MEM_LENGTH));

    state_t      state;
    logic [7:0]  opcode;
    logic [2:0]  byte_cnt;
    logic [23:0] shift;

    logic        accept;
    logic        last;
    logic        expire;
    logic        range_ok;
    logic        err_set;
    logic [31:0] pl;

    assign rx_ready = (state != ISSUE);
    assign busy     = (state != IDLE);
    assign accept   = rx_valid && rx_ready;
    assign last     = (state == PAYLOAD) && accept && (byte_cnt == 3'd1);

    // Payload right-aligned with the byte arriving this cycle in the low lane,
    // so every field sits at a fixed position regardless of frame length.
    assign pl = {shift, rx_data};

    // Range checks run on full 8-bit fields before any truncation to address width.
    always_comb begin
        range_ok = 1'b0;
        case (opcode)
            OP_WR_MEM: range_ok = ({1'b0, pl[31:24]} < LEN_LIMIT) && (pl[23:16] < LANE_LIMIT);
            OP_WR_DOT: range_ok = (pl[23:16] < LANE_LIMIT);
            OP_WR_SEL: range_ok = ({1'b0, pl[15:8]} < LEN_LIMIT) && ({1'b0, pl[7:0]} < LEN_LIMIT);
            default:   range_ok = 1'b0;
        endcase
    end

    assign err_set = ((state == IDLE) && accept && (payload_len(rx_data) == 3'd0))
                  || (last && !range_ok)
                  || ((state == PAYLOAD) && expire);

    dot_seq_loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock (clock),
        .reset (reset),
        .clear ((state != PAYLOAD) || accept),
        .enable((state == PAYLOAD) && !accept),
        .expire(expire)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state               <= IDLE;
            opcode              <= '0;
            byte_cnt            <= '0;
            mem_write_n         <= 1'b1;
            mem_dot_write_n     <= 1'b1;
            mem_sel_write_n     <= 1'b1;
            mask_select         <= '0;
            mem_address         <= '0;
            mem_data            <= '0;
            mem_dot_data        <= '0;
            mem_sel_col_address <= '0;
            mem_sel_data        <= '0;
            frame_done          <= 1'b0;
            error               <= 1'b0;
            write_count         <= '0;
        end else begin
            mem_write_n     <= 1'b1;
            mem_dot_write_n <= 1'b1;
            mem_sel_write_n <= 1'b1;
            frame_done      <= 1'b0;

            if (err_set) begin
                error <= 1'b1;
            end else if (err_clear) begin
                error <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        opcode   <= rx_data;
                        byte_cnt <= payload_len(rx_data);
                        if (payload_len(rx_data) == 3'd0) begin
                            frame_done <= 1'b1;
                        end else begin
                            state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        shift    <= {shift[15:0], rx_data};
                        byte_cnt <= byte_cnt - 3'd1;
                        if (last) begin
                            state      <= ISSUE;
                            frame_done <= 1'b1;
                            if (range_ok) begin
                                write_count <= write_count + 16'd1;
                                case (opcode)
                                    OP_WR_MEM: begin
                                        mem_write_n <= 1'b0;
                                        mem_address <= pl[24 +: MEM_ADDRESS_LENGTH];
                                        mask_select <= pl[18:16];
                                        mem_data    <= pl[15:0];
                                    end
                                    OP_WR_DOT: begin
                                        mem_dot_write_n <= 1'b0;
                                        mask_select     <= pl[18:16];
                                        mem_dot_data    <= pl[15:0];
                                    end
                                    default: begin
                                        mem_sel_write_n     <= 1'b0;
                                        mem_sel_col_address <= pl[8 +: MEM_ADDRESS_LENGTH];
                                        mem_sel_data        <= pl[0 +: MEM_ADDRESS_LENGTH];
                                    end
                                endcase
                            end
                        end
                    end else if (expire) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_sequencer_loader.sv
// Bench for dot_sequencer_loader: table of single frames plus hand-built
// multi-cycle sequences, with a strobe scoreboard checked on the falling edge.
module tb_dot_sequencer_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [2:0]  mask_select;
    logic [5:0]  mem_address;
    logic [15:0] mem_data;
    logic        mem_write_n;
    logic [15:0] mem_dot_data;
    logic        mem_dot_write_n;
    logic [5:0]  mem_sel_col_address;
    logic [5:0]  mem_sel_data;
    logic        mem_sel_write_n;
    logic        busy;
    logic        frame_done;
    logic        error;
    logic        err_clear;
    logic [15:0] write_count;

    dot_sequencer_loader dut (
        .clock              (clock),
        .reset              (reset),
        .rx_data            (rx_data),
        .rx_valid           (rx_valid),
        .rx_ready           (rx_ready),
        .mask_select        (mask_select),
        .mem_address        (mem_address),
        .mem_data           (mem_data),
        .mem_write_n        (mem_write_n),
        .mem_dot_data       (mem_dot_data),
        .mem_dot_write_n    (mem_dot_write_n),
        .mem_sel_col_address(mem_sel_col_address),
        .mem_sel_data       (mem_sel_data),
        .mem_sel_write_n    (mem_sel_write_n),
        .busy               (busy),
        .frame_done         (frame_done),
        .error              (error),
        .err_clear          (err_clear),
        .write_count        (write_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [39:0] bytes;
        int          n;
        bit          strobe;
        int          kind;
        logic [5:0]  addr;
        logic [2:0]  mask;
        logic [15:0] data;
        bit          err;
    } vec_t;

    typedef struct {
        int          kind;
        logic [5:0]  addr;
        logic [2:0]  mask;
        logic [15:0] data;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[12];
    int   checks = 0;
    int   fails = 0;
    int   fd_count = 0;
    int   exp_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        int   lows;
        int   kind;
        exp_t e;
        lows = 0;
        if (frame_done) fd_count++;
        if (!mem_write_n) lows++;
        if (!mem_dot_write_n) lows++;
        if (!mem_sel_write_n) lows++;
        if (lows != 0) begin
            check("strobe_exclusive", lows, 1);
            kind = !mem_write_n ? 0 : (!mem_dot_write_n ? 1 : 2);
            if (sbq.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_strobe: got kind %0d expected none", kind);
            end else begin
                e = sbq.pop_front();
                check("strobe_kind", kind, e.kind);
                if (kind == 0) begin
                    check("mem_address", mem_address, e.addr);
                    check("mem_mask", mask_select, e.mask);
                    check("mem_data", mem_data, e.data);
                end else if (kind == 1) begin
                    check("dot_mask", mask_select, e.mask);
                    check("dot_data", mem_dot_data, e.data);
                end else begin
                    check("sel_col", mem_sel_col_address, e.addr);
                    check("sel_data", mem_sel_data, e.data[5:0]);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clock);
            if (rx_ready) done = 1;
            @(posedge clock);
            #1;
        end
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL byte_accept_timeout: got rx_ready 0 expected 1 within 20 cycles");
        end
    endtask

    task automatic send_frame(input logic [39:0] bytes, input int n);
        for (int i = 0; i < n; i++) send_byte(bytes[39-8*i -: 8]);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input int kind, input logic [5:0] addr, input logic [2:0] mask,
                            input logic [15:0] data);
        exp_t e;
        e.kind = kind;
        e.addr = addr;
        e.mask = mask;
        e.data = data;
        sbq.push_back(e);
        exp_count++;
    endtask

    task automatic clear_error();
        err_clear = 1'b1;
        idle(1);
        err_clear = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fd0;
        vecs[0]  = '{bytes: 40'h01_05_01_AB_CD, n: 5, strobe: 1'b1, kind: 0, addr: 6'd5,  mask: 3'd1, data: 16'hABCD, err: 1'b0};
        vecs[1]  = '{bytes: 40'h02_00_12_34_00, n: 4, strobe: 1'b1, kind: 1, addr: 6'd0,  mask: 3'd0, data: 16'h1234, err: 1'b0};
        vecs[2]  = '{bytes: 40'h03_2F_07_00_00, n: 3, strobe: 1'b1, kind: 2, addr: 6'd47, mask: 3'd0, data: 16'h0007, err: 1'b0};
        vecs[3]  = '{bytes: 40'h01_30_00_FF_FF, n: 5, strobe: 1'b0, kind: 0, addr: 6'd0,  mask: 3'd0, data: 16'h0000, err: 1'b1};
        vecs[4]  = '{bytes: 40'h01_00_03_00_00, n: 5, strobe: 1'b0, kind: 0, addr: 6'd0,  mask: 3'd0, data: 16'h0000, err: 1'b1};
        vecs[5]  = '{bytes: 40'h01_46_00_11_22, n: 5, strobe: 1'b0, kind: 0, addr: 6'd0,  mask: 3'd0, data: 16'h0000, err: 1'b1};
        vecs[6]  = '{bytes: 40'h02_08_00_00_00, n: 4, strobe: 1'b0, kind: 1, addr: 6'd0,  mask: 3'd0, data: 16'h0000, err: 1'b1};
        vecs[7]  = '{bytes: 40'h03_30_00_00_00, n: 3, strobe: 1'b0, kind: 2, addr: 6'd0,  mask: 3'd0, data: 16'h0000, err: 1'b1};
        vecs[8]  = '{bytes: 40'h03_00_30_00_00, n: 3, strobe: 1'b0, kind: 2, addr: 6'd0,  mask: 3'd0, data: 16'h0000, err: 1'b1};
        vecs[9]  = '{bytes: 40'h01_2F_02_FF_FF, n: 5, strobe: 1'b1, kind: 0, addr: 6'd47, mask: 3'd2, data: 16'hFFFF, err: 1'b0};
        vecs[10] = '{bytes: 40'h7E_00_00_00_00, n: 1, strobe: 1'b0, kind: 0, addr: 6'd0,  mask: 3'd0, data: 16'h0000, err: 1'b1};
        vecs[11] = '{bytes: 40'h00_00_00_00_00, n: 1, strobe: 1'b0, kind: 0, addr: 6'd0,  mask: 3'd0, data: 16'h0000, err: 1'b1};

        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        err_clear = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_strobes", {mem_write_n, mem_dot_write_n, mem_sel_write_n}, 3'b111);
        check("rst_write_count", write_count, 0);
        check("rst_error", error, 0);
        check("rst_busy", busy, 0);
        check("rst_rx_ready", rx_ready, 1);
        check("rst_frame_done", frame_done, 0);
        check("rst_mem_address", mem_address, 0);
        @(posedge clock);
        #1;

        for (int i = 0; i < 12; i++) begin
            clear_error();
            fd0 = fd_count;
            if (vecs[i].strobe) push_exp(vecs[i].kind, vecs[i].addr, vecs[i].mask, vecs[i].data);
            send_frame(vecs[i].bytes, vecs[i].n);
            idle(3);
            check($sformatf("vec%0d_error", i), error, vecs[i].err);
            check($sformatf("vec%0d_write_count", i), write_count, exp_count);
            check($sformatf("vec%0d_frame_done", i), fd_count - fd0, 1);
            check($sformatf("vec%0d_busy", i), busy, 0);
            check($sformatf("vec%0d_pending", i), sbq.size(), 0);
        end

        // Back-to-back frames with rx_valid held high across the ISSUE stall.
        clear_error();
        fd0 = fd_count;
        push_exp(1, 6'd0, 3'd0, 16'h1234);
        push_exp(2, 6'd47, 3'd0, 16'h0007);
        send_frame(40'h02_00_12_34_00, 4);
        @(negedge clock);
        check("b2b_stall1_ready", rx_ready, 0);
        check("b2b_stall1_busy", busy, 1);
        send_frame(40'h03_2F_07_00_00, 3);
        @(negedge clock);
        check("b2b_stall2_ready", rx_ready, 0);
        idle(3);
        check("b2b_pending", sbq.size(), 0);
        check("b2b_write_count", write_count, exp_count);
        check("b2b_frame_done", fd_count - fd0, 2);
        check("b2b_error", error, 0);

        // Error set wins over a simultaneous clear.
        clear_error();
        send_frame(40'h7E_00_00_00_00, 1);
        rx_valid = 1'b0;
        @(negedge clock);
        check("illegal_error", error, 1);
        check("illegal_busy", busy, 0);
        err_clear = 1'b1;
        send_byte(8'h55);
        err_clear = 1'b0;
        rx_valid  = 1'b0;
        @(negedge clock);
        check("err_set_priority", error, 1);
        clear_error();
        @(negedge clock);
        check("err_clear_alone", error, 0);
        @(posedge clock);
        #1;

        // Inter-byte timeout aborts the frame, next frame runs normally.
        fd0 = fd_count;
        send_frame(40'h01_02_00_00_00, 2);
        rx_valid = 1'b0;
        repeat (1000) @(posedge clock);
        @(negedge clock);
        check("timeout_early_error", error, 0);
        check("timeout_early_busy", busy, 1);
        repeat (30) @(posedge clock);
        @(negedge clock);
        check("timeout_error", error, 1);
        check("timeout_busy", busy, 0);
        check("timeout_frame_done", fd_count - fd0, 1);
        @(posedge clock);
        #1;
        clear_error();
        push_exp(2, 6'd1, 3'd0, 16'h0001);
        send_frame(40'h03_01_01_00_00, 3);
        idle(3);
        check("post_timeout_count", write_count, exp_count);
        check("post_timeout_pending", sbq.size(), 0);
        check("post_timeout_error", error, 0);

        // Reset in the middle of a WR_MEM frame discards it.
        send_frame(40'h01_05_01_00_00, 3);
        rx_valid = 1'b0;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        @(negedge clock);
        check("midrst_strobes", {mem_write_n, mem_dot_write_n, mem_sel_write_n}, 3'b111);
        check("midrst_write_count", write_count, 0);
        check("midrst_busy", busy, 0);
        check("midrst_error", error, 0);
        check("midrst_mem_address", mem_address, 0);
        check("midrst_mask", mask_select, 0);
        @(posedge clock);
        #1;
        exp_count = 0;
        push_exp(2, 6'd0, 3'd0, 16'h0009);
        send_frame(40'h03_00_09_00_00, 3);
        idle(3);
        check("midrst_sel_count", write_count, exp_count);
        check("midrst_pending", sbq.size(), 0);
        check("midrst_no_wrmem_addr", mem_address, 0);
        check("midrst_no_wrmem_data", mem_data, 0);

        check("final_pending", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
